div_seq: RTL and testbench

//  Multi-cycle 32-bit divider controller and datapath for the EX stage (DIV/DIVU).
//  - Sequences a radix-2 restoring division, one quotient bit per cycle.
//  - Raises stallreq_for_ex to the stall controller while busy, so PC..EX freeze.
//  - Delivers {remainder, quotient} to EX for the HI/LO write.

---
 rtl/div_seq_pkg.sv | 18 +
 rtl/div_step.sv | 23 ++
 rtl/div_seq.sv | 159 +++++++++++++++
 tb/tb_div_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// Shared types and constants for the sequential divider: FSM state encoding,
// stall request levels and the default operand width.
package div_seq_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  // Stall request levels driven towards the pipeline stall controller.
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_ZERO = 2'b10,
    DIV_DONE = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// trial-subtract the divisor magnitude, keep the difference if no borrow.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             dividend_bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             quot_bit_o
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // rem_i < divisor_i always holds, so trial fits in WIDTH+1 bits and the
  // top bit of diff is a clean borrow flag.
  assign trial      = {rem_i, dividend_bit_i};
  assign diff       = trial - {1'b0, divisor_i};
  assign quot_bit_o = ~diff[WIDTH];
  assign rem_o      = quot_bit_o ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU unit for the EX stage: FSM, operand and sign registers,
// restoring iteration and sign fix-up. Optional feature macro: DIV_EARLY_OUT_EN.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_start_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               flush_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_for_ex
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dividend_q, dividend_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic               sign_a_q, sign_a_d;
  logic               neg_quot_q, neg_quot_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic             sign_a, sign_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             early_out;
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic [WIDTH-1:0] quot_next;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  assign sign_a = signed_div_i & opdata1_i[WIDTH-1];
  assign sign_b = signed_div_i & opdata2_i[WIDTH-1];
  assign abs_a  = sign_a ? -opdata1_i : opdata1_i;
  assign abs_b  = sign_b ? -opdata2_i : opdata2_i;

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (abs_a < abs_b);
`else
  assign early_out = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i          (rem_q),
    .divisor_i      (divisor_q),
    .dividend_bit_i (dividend_q[WIDTH-1]),
    .rem_o          (step_rem),
    .quot_bit_o     (step_qbit)
  );

  // Final step result is fixed up directly so DONE can present it registered.
  assign quot_next = {quot_q[WIDTH-2:0], step_qbit};
  assign quot_fix  = neg_quot_q ? -quot_next : quot_next;
  assign rem_fix   = sign_a_q   ? -step_rem  : step_rem;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch can be inferred.
    state_d         = state_q;
    cnt_d           = cnt_q;
    dividend_d      = dividend_q;
    divisor_d       = divisor_q;
    rem_d           = rem_q;
    quot_d          = quot_q;
    sign_a_d        = sign_a_q;
    neg_quot_d      = neg_quot_q;
    result_d        = result_q;
    ready_o         = 1'b0;
    stallreq_for_ex = NO_STOP;

    if (flush_i) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          stallreq_for_ex = div_start_i ? STOP : NO_STOP;
          if (div_start_i) begin
            if (opdata2_i == '0) begin
              state_d  = DIV_ZERO;
              result_d = '0;
            end else if (early_out) begin
              state_d  = DIV_DONE;
              result_d = {opdata1_i, {WIDTH{1'b0}}};
            end else begin
              state_d    = DIV_BUSY;
              cnt_d      = '0;
              dividend_d = abs_a;
              divisor_d  = abs_b;
              rem_d      = '0;
              quot_d     = '0;
              sign_a_d   = sign_a;
              neg_quot_d = sign_a ^ sign_b;
            end
          end
        end
        DIV_BUSY: begin
          stallreq_for_ex = STOP;
          rem_d           = step_rem;
          quot_d          = quot_next;
          dividend_d      = {dividend_q[WIDTH-2:0], 1'b0};
          cnt_d           = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d  = DIV_DONE;
            cnt_d    = '0;
            result_d = {rem_fix, quot_fix};
          end
        end
        DIV_ZERO: begin
          ready_o = 1'b1;
          state_d = DIV_IDLE;
        end
        DIV_DONE: begin
          ready_o = 1'b1;
          state_d = DIV_IDLE;
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments only; the reset is
  // synchronous and clears every register, operand registers included.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      sign_a_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      sign_a_q   <= sign_a_d;
      neg_quot_q <= neg_quot_d;
      result_q   <= result_d;
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: scoreboard of {remainder, quotient} and
// latency per division, plus flush, reset and back-to-back scenarios.
module tb_div_seq;

  localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic           div_start;
  logic           signed_div;
  logic [W-1:0]   op1, op2;
  logic           flush;
  logic [2*W-1:0] result;
  logic           ready;
  logic           stall;

  div_seq #(.WIDTH(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .div_start_i     (div_start),
    .signed_div_i    (signed_div),
    .opdata1_i       (op1),
    .opdata2_i       (op2),
    .flush_i         (flush),
    .result_o        (result),
    .ready_o         (ready),
    .stallreq_for_ex (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] result;
    int             lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit signed arithmetic never overflows for 32-bit operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
    exp_t   e;
    longint sa, sbv, q, r, ma, mb;
    sa  = sgn ? longint'($signed(a)) : longint'(a);
    sbv = sgn ? longint'($signed(b)) : longint'(b);
    if (b == '0) begin
      e.result = '0;
      e.lat    = 1;
    end else begin
      q        = sa / sbv;
      r        = sa % sbv;
      e.result = {r[W-1:0], q[W-1:0]};
      ma       = (sa < 0) ? -sa : sa;
      mb       = (sbv < 0) ? -sbv : sbv;
      e.lat    = (EARLY && ma < mb) ? 1 : W + 1;
    end
    return e;
  endfunction

  // Called #1 after a rising edge; that cycle is cycle 0 of the division.
  // Returns #1 after the edge that ends the ready cycle, start dropped.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                         input string tag);
    exp_t e;
    bit   stall_ok  = 1'b1;
    bit   got_ready = 1'b0;
    int   cyc       = 0;
    sb_q.push_back(model(a, b, sgn));
    div_start  = 1'b1;
    signed_div = sgn;
    op1        = a;
    op2        = b;
    while (!got_ready && cyc < 100) begin
      @(negedge clk);
      if (ready) begin
        got_ready = 1'b1;
        e = sb_q.pop_front();
        if (stall !== 1'b0) stall_ok = 1'b0;
        check({tag, " result"}, 64'(result), 64'(e.result));
        check({tag, " latency"}, 64'(cyc), 64'(e.lat));
      end else begin
        if (stall !== 1'b1) stall_ok = 1'b0;
        cyc++;
      end
    end
    check({tag, " ready_seen"}, 64'(got_ready), 64'(1));
    if (!got_ready) void'(sb_q.pop_front());
    check({tag, " stall_profile"}, 64'(stall_ok), 64'(1));
    @(posedge clk);
    #1;
    div_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit early_ready;
    rst = 1'b0; div_start = 1'b0; signed_div = 1'b0; flush = 1'b0; op1 = '0; op2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ready", 64'(ready), 64'(0));
    check("reset stall", 64'(stall), 64'(0));
    check("reset result", 64'(result), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed cases, issued back to back (start re-asserted right after DONE).
    run_div(32'd100, 32'd7, 1'b0, "divu_100_7");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2");
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, "div_7_m2");
    run_div(32'd5, 32'd0, 1'b0, "divu_5_0");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_min_m1");
    run_div(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, "div_m100_m7");
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, "divu_max_1");
    run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "divu_max_max");
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 28);
      if (b == '0) b = 32'd1;
      run_div(a, b, 1'(i % 2), "rand");
    end
    @(negedge clk);
    check("no stuck ready", 64'(ready), 64'(0));

    // Flush at cycle 10 of a running division.
    @(posedge clk); #1;
    div_start = 1'b1; signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3;
    early_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready) early_ready = 1'b1;
      @(posedge clk);
    end
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush stall", 64'(stall), 64'(0));
    check("flush ready", 64'(ready), 64'(0));
    check("pre-flush ready", 64'(early_ready), 64'(0));
    @(posedge clk); #1;
    flush = 1'b0; div_start = 1'b0;
    @(negedge clk);
    check("post-flush ready", 64'(ready), 64'(0));
    check("post-flush stall", 64'(stall), 64'(0));
    @(posedge clk); #1;
    run_div(32'd9, 32'd3, 1'b0, "divu_9_3_after_flush");

    // Start coinciding with flush is ignored (divide-by-zero would pulse at cycle 1).
    div_start = 1'b1; op1 = 32'd5; op2 = 32'd0; flush = 1'b1;
    @(negedge clk);
    check("start+flush stall", 64'(stall), 64'(0));
    @(posedge clk); #1;
    div_start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("start+flush ready", 64'(ready), 64'(0));
    check("start+flush result", 64'(result), 64'({32'd0, 32'd3}));

    // Reset at cycle 5 of a running division.
    @(posedge clk); #1;
    div_start = 1'b1; signed_div = 1'b0; op1 = 32'd200; op2 = 32'd7;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0; div_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midreset ready", 64'(ready), 64'(0));
    check("midreset stall", 64'(stall), 64'(0));
    check("midreset result", 64'(result), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    run_div(32'd5, 32'd9, 1'b0, "divu_5_9");
    run_div(32'hFFFF_FFFB, 32'd9, 1'b1, "div_m5_9");

    @(negedge clk);
    check("final idle ready", 64'(ready), 64'(0));
    check("scoreboard empty", 64'(sb_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
